// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: shared defaults, index widths and per-state config record for the payload sequence engine
package payload_engine_pkg;
  localparam int NUM_STATES_DEF = 32;
  localparam int NUM_CLASSES_DEF = 64;
  localparam int OFS_W_DEF = 16;
  localparam int STATE_IDX_W = $clog2(NUM_STATES_DEF);
  localparam int CLASS_IDX_W = $clog2(NUM_CLASSES_DEF);
  localparam int CLS_REC_W = 8;
  typedef struct packed {
    logic [CLS_REC_W-1:0] cls;
    logic                 loop;
  } state_cfg_t;
  function automatic int clamp_len(input int len, input int max_len);
    return len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/payload_seq_state_cell.sv
// payload_seq_state_cell: one NFA state bit with async reset and sync clear
module payload_seq_state_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic keep,
  input  logic hit,
  input  logic act_in,
  input  logic loop,
  output logic q,
  output logic nxt
);
  logic q_q, q_d;
  assign q_d = en ? keep & hit & (act_in | (loop & q_q & ~clr)) : keep & q_q & ~clr;
  assign q = q_q;
  assign nxt = q_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 1'b0;
    else q_q <= q_d;
endmodule

// File: rtl/payload_seq_engine.sv
// payload_seq_engine: programmable byte-class NFA sequence matcher with sticky match.
// Define PAYLOAD_SEQ_OFFSET_EN to build the byte counter and match_ofs capture.
module payload_seq_engine
  import payload_engine_pkg::*;
#(
  parameter int NUM_STATES  = NUM_STATES_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int OFS_W       = OFS_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sod,
  input  logic                           en,
  input  logic [NUM_CLASSES-1:0]         in_class,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_STATES)-1:0]  cfg_addr,
  input  logic [$clog2(NUM_CLASSES)-1:0] cfg_class,
  input  logic                           cfg_loop,
  input  logic                           ctl_we,
  input  logic [$clog2(NUM_STATES):0]    ctl_len,
  input  logic                           ctl_anchor,
  output logic                           match,
  output logic [OFS_W-1:0]               match_ofs,
  output logic                           active
);
  localparam int LW = $clog2(NUM_STATES) + 1;
  state_cfg_t [NUM_STATES-1:0] cfg_q, cfg_d;
  logic [LW-1:0] len_q, len_d;
  logic anchor_q, anchor_d, first_q, first_d, match_q, match_d;
  logic clr, fin;
  logic [NUM_STATES-1:0] s_q, s_d, hit, act_in, keep, fin_mask;
  // any program write restarts the context exactly like sod
  assign clr = sod | cfg_we | ctl_we;
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we) cfg_d[cfg_addr] = '{cls: CLS_REC_W'(cfg_class), loop: cfg_loop};
    len_d = ctl_we ? LW'(clamp_len(int'(ctl_len), NUM_STATES)) : len_q;
    anchor_d = ctl_we ? ctl_anchor : anchor_q;
    first_d = ~en & (clr | first_q);
    match_d = fin | (match_q & ~clr);
  end
  for (genvar k = 0; k < NUM_STATES; k++) begin : g_st
    assign hit[k] = |(in_class & (NUM_CLASSES'(1) << cfg_q[k].cls));
    assign keep[k] = LW'(k) < len_q;
    assign fin_mask[k] = LW'(k + 1) == len_q;
    if (k == 0) begin : g_head
      assign act_in[0] = ~anchor_q | first_q | clr;
    end else begin : g_tail
      assign act_in[k] = (s_q[k-1] & ~clr) | (cfg_q[k-1].loop & act_in[k-1]);
    end
    payload_seq_state_cell u_cell (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .keep(keep[k]), .hit(hit[k]),
      .act_in(act_in[k]), .loop(cfg_q[k].loop), .q(s_q[k]), .nxt(s_d[k])
    );
  end
  assign fin = |(s_d & fin_mask);
  assign match = match_q;
  assign active = |s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg_q <= '0;
      len_q <= '0;
      anchor_q <= 1'b0;
      first_q <= 1'b1;
      match_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      len_q <= len_d;
      anchor_q <= anchor_d;
      first_q <= first_d;
      match_q <= match_d;
    end
`ifdef PAYLOAD_SEQ_OFFSET_EN
  logic [OFS_W-1:0] cnt_q, cnt_d, ofs_q, ofs_d, cur;
  // cur is the offset of this cycle's byte; the counter sticks at all-ones
  always_comb begin
    cur = clr ? '0 : cnt_q;
    cnt_d = en ? (&cur ? cur : cur + OFS_W'(1)) : cur;
    ofs_d = (fin & ~(match_q & ~clr)) ? cur : (clr ? '0 : ofs_q);
  end
  assign match_ofs = ofs_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      ofs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ofs_q <= ofs_d;
    end
`else
  assign match_ofs = '0;
`endif
endmodule

// File: tb/tb_payload_seq_engine.sv
// tb_payload_seq_engine: table-driven pattern checks plus hand-written sod/saturation/reset sequences
module tb_payload_seq_engine;
`ifdef PAYLOAD_SEQ_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif
  localparam int C_A = 0, C_B = 1, C_C = 2, C_X = 3, C_Y = 4, C_NNL = 5, C_FILL = 6;
  typedef struct {
    int    prog;
    string s;
    bit    m;
    int    ofs;
  } row_t;
  localparam int NR = 7;
  row_t rows[NR];
  logic clk = 0, rst = 1, sod = 0, en = 0, cfg_we = 0, cfg_loop = 0, ctl_we = 0, ctl_anchor = 0;
  logic [63:0] in_class = '0;
  logic [4:0] cfg_addr = '0;
  logic [5:0] cfg_class = '0;
  logic [5:0] ctl_len = '0;
  logic m16, a16, m4, a4;
  logic [15:0] o16;
  logic [3:0] o4;
  int n_chk = 0, n_fail = 0;

  payload_seq_engine dut (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .in_class(in_class),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_class(cfg_class), .cfg_loop(cfg_loop),
    .ctl_we(ctl_we), .ctl_len(ctl_len), .ctl_anchor(ctl_anchor),
    .match(m16), .match_ofs(o16), .active(a16)
  );
  payload_seq_engine #(.OFS_W(4)) dut4 (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .in_class(in_class),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_class(cfg_class), .cfg_loop(cfg_loop),
    .ctl_we(ctl_we), .ctl_len(ctl_len), .ctl_anchor(ctl_anchor),
    .match(m4), .match_ofs(o4), .active(a4)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cls_of(input byte b);
    logic [63:0] v;
    v = '0;
    v[C_A] = b == "A";
    v[C_B] = b == "B";
    v[C_C] = b == "C";
    v[C_X] = b == "X";
    v[C_Y] = b == "Y";
    v[C_NNL] = b != 8'h0d && b != 8'h0a;
    v[C_FILL] = b == "x" || b == "q";
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int c, input int l);
    cfg_we = 1; cfg_addr = 5'(a); cfg_class = 6'(c); cfg_loop = l[0];
    tick();
    cfg_we = 0; cfg_loop = 0;
  endtask

  task automatic load_prog(input int id);
    if (id == 2) begin
      wr(0, C_X, 0); wr(1, C_NNL, 1); wr(2, C_Y, 0);
    end else begin
      wr(0, C_A, 0); wr(1, C_B, 0); wr(2, C_C, 0);
    end
    ctl_we = 1; ctl_len = 6'd3; ctl_anchor = (id == 3);
    tick();
    ctl_we = 0; ctl_anchor = 0;
  endtask

  task automatic start();
    sod = 1;
    tick();
    sod = 0;
  endtask

  task automatic send(input byte b, input bit s);
    en = 1; sod = s; in_class = cls_of(b);
    tick();
    en = 0; sod = 0; in_class = '0;
  endtask

  initial begin
    rows[0] = '{1, "xxABC", 1, 4};
    rows[1] = '{2, "XqqY", 1, 3};
    rows[2] = '{2, "XY", 1, 1};
    rows[3] = '{2, "X\nY", 0, 0};
    rows[4] = '{3, "xABC", 0, 0};
    rows[5] = '{3, "ABC", 1, 2};
    rows[6] = '{1, "ABCABC", 1, 2};
    #2;
    check("reset match", m16, 0);
    check("reset match_ofs", o16, 0);
    check("reset active", a16, 0);
    #10 rst = 0;
    for (int r = 0; r < NR; r++) begin
      load_prog(rows[r].prog);
      start();
      for (int i = 0; i < rows[r].s.len(); i++) begin
        send(rows[r].s[i], 0);
        check($sformatf("row%0d match@%0d", r, i), m16, rows[r].m && i >= rows[r].ofs);
      end
      check($sformatf("row%0d match_ofs", r), o16, OFS_EN ? rows[r].ofs : 0);
      check($sformatf("row%0d match_ofs w4", r), o4, OFS_EN ? rows[r].ofs : 0);
    end
    load_prog(1);
    start();
    send("A", 0);
    send("B", 0);
    check("sod-split active before", a16, 1);
    send("C", 1);
    check("sod-split match", m16, 0);
    check("sod-split active", a16, 0);
    start();
    for (int i = 0; i < 20; i++) send("x", 0);
    send("A", 0);
    send("B", 0);
    send("C", 0);
    check("sat match", m16, 1);
    check("sat match w4", m4, 1);
    check("sat match_ofs", o16, OFS_EN ? 22 : 0);
    check("sat match_ofs w4", o4, OFS_EN ? 15 : 0);
    start();
    send("A", 0);
    send("B", 0);
    check("rst pre active", a16, 1);
    #2 rst = 1;
    #1;
    check("rst async active", a16, 0);
    check("rst async match", m16, 0);
    check("rst async match_ofs", o16, 0);
    check("rst async match w4", m4, 0);
    tick();
    check("rst held active", a16, 0);
    #2 rst = 0;
    send("C", 0);
    check("rst post match", m16, 0);
    check("rst post active", a16, 0);
    load_prog(1);
    start();
    send("A", 0);
    send("B", 0);
    send("C", 0);
    check("reprog match", m16, 1);
    check("reprog match_ofs", o16, OFS_EN ? 2 : 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
